// File: rtl/core_ctrl_fsm.sv
`timescale 1ns/1ps
// core_ctrl_fsm: multi-cycle instruction sequencer for the FRiscV core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the PC, IR,
// ALU operand, register file and data memory controls, and traps on illegal opcodes.
module core_ctrl_fsm #(
    parameter int ARCH        = 32,
    parameter int RESET_STALL = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [6:0]      op_code_in,
    input  logic            imem_ack_in,
    input  logic            dmem_ack_in,
    input  logic            branch_taken_in,
    output logic            imem_req_out,
    output logic            ir_we_out,
    output logic            pc_we_out,
    output logic [1:0]      pc_sel_out,
    output logic            alu_b_sel_out,
    output logic            rf_we_out,
    output logic [1:0]      wb_sel_out,
    output logic            dmem_req_out,
    output logic            dmem_we_out,
    output logic            illegal_instr_out,
    output logic            retire_out,
    output logic [ARCH-1:0] retire_cnt_out,
    output logic [2:0]      state_out
);

    // FRiscV major opcodes (RV32I encodings)
    localparam logic [6:0] OP_REG       = 7'b0110011;
    localparam logic [6:0] OP_IMM_ARITH = 7'b0010011;
    localparam logic [6:0] OP_IMM_JUMP  = 7'b1100111;
    localparam logic [6:0] OP_IMM_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_U_L_LOAD  = 7'b0110111;
    localparam logic [6:0] OP_JUMP      = 7'b1101111;

    // Next-PC sources
    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_IMM    = 2'd1;
    localparam logic [1:0] PC_RS1IMM = 2'd2;

    // Writeback sources
    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_DMEM = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;
    localparam logic [1:0] WB_IMM  = 2'd3;

    typedef enum logic [2:0] {
        S_STALL  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_e;

    // A zero stall skips STALL entirely, so reset lands directly in FETCH.
    localparam state_e     RESET_STATE = (RESET_STALL == 0) ? S_FETCH : S_STALL;
    localparam logic [3:0] STALL_LAST  = (RESET_STALL > 0) ? 4'(RESET_STALL - 1) : 4'd0;

    state_e          state_q, state_d;
    logic [6:0]      op_q, op_d;
    logic [3:0]      stall_cnt_q, stall_cnt_d;
    logic [ARCH-1:0] retire_cnt_q, retire_cnt_d;
    logic            illegal_q, illegal_d;

    // Decoded controls before reset gating
    logic       imem_req, ir_we, pc_we, alu_b_sel, rf_we, dmem_req, dmem_we, retire;
    logic [1:0] pc_sel, wb_sel;

    function automatic logic op_is_legal(input logic [6:0] op);
        logic legal;
        case (op)
            OP_REG, OP_IMM_ARITH, OP_IMM_JUMP, OP_IMM_LOAD,
            OP_STORE, OP_BRANCH, OP_U_L_LOAD, OP_JUMP: legal = 1'b1;
            default:                                   legal = 1'b0;
        endcase
        return legal;
    endfunction

    // Next-state, opcode latch, stall counter, trap flag and retire counter
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        op_d         = op_q;
        stall_cnt_d  = stall_cnt_q;
        illegal_d    = illegal_q;
        retire_cnt_d = retire_cnt_q + ARCH'(retire);

        case (state_q)
            S_STALL: begin
                if (stall_cnt_q == STALL_LAST) begin
                    state_d = S_FETCH;
                end else begin
                    stall_cnt_d = stall_cnt_q + 4'd1;
                end
            end
            S_FETCH: begin
                if (imem_ack_in) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                op_d = op_code_in;
                if (op_is_legal(op_code_in)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_BRANCH:             state_d = S_FETCH;
                    OP_IMM_LOAD, OP_STORE: state_d = S_MEM;
                    default:               state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (dmem_ack_in) begin
                    state_d = (op_q == OP_STORE) ? S_FETCH : S_WB;
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = RESET_STATE;
        endcase
    end

    // Control decode from current state and latched opcode; acks and branch_taken
    // only qualify strobes in the cycle they arrive
    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        alu_b_sel = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = WB_ALU;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        retire    = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ack_in;
            end
            S_EXEC: begin
                case (op_q)
                    OP_IMM_ARITH, OP_IMM_LOAD, OP_STORE, OP_IMM_JUMP: alu_b_sel = 1'b1;
                    OP_BRANCH: begin
                        pc_we  = 1'b1;
                        pc_sel = branch_taken_in ? PC_IMM : PC_PLUS4;
                        retire = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op_q == OP_STORE);
                if (dmem_ack_in && (op_q == OP_STORE)) begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end
            end
            S_WB: begin
                rf_we  = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
                case (op_q)
                    OP_IMM_LOAD:          wb_sel = WB_DMEM;
                    OP_JUMP, OP_IMM_JUMP: wb_sel = WB_PC4;
                    OP_U_L_LOAD:          wb_sel = WB_IMM;
                    default:              wb_sel = WB_ALU;
                endcase
                case (op_q)
                    OP_JUMP:     pc_sel = PC_IMM;
                    OP_IMM_JUMP: pc_sel = PC_RS1IMM;
                    default:     pc_sel = PC_PLUS4;
                endcase
            end
            default: ;
        endcase
    end

    // State and bookkeeping registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RESET_STATE;
            op_q         <= 7'd0;
            stall_cnt_q  <= 4'd0;
            retire_cnt_q <= '0;
            illegal_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of the others.
            state_q      <= state_d;
            op_q         <= op_d;
            stall_cnt_q  <= stall_cnt_d;
            retire_cnt_q <= retire_cnt_d;
            illegal_q    <= illegal_d;
        end
    end

    // Reset drops every request, strobe and select at once, even mid-handshake
    assign imem_req_out      = imem_req  & ~rst;
    assign ir_we_out         = ir_we     & ~rst;
    assign pc_we_out         = pc_we     & ~rst;
    assign pc_sel_out        = rst ? PC_PLUS4 : pc_sel;
    assign alu_b_sel_out     = alu_b_sel & ~rst;
    assign rf_we_out         = rf_we     & ~rst;
    assign wb_sel_out        = rst ? WB_ALU : wb_sel;
    assign dmem_req_out      = dmem_req  & ~rst;
    assign dmem_we_out       = dmem_we   & ~rst;
    assign retire_out        = retire    & ~rst;
    assign illegal_instr_out = illegal_q;
    assign retire_cnt_out    = retire_cnt_q;
    assign state_out         = state_q;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
`timescale 1ns/1ps
// Testbench for core_ctrl_fsm: randomized instruction stream with a scoreboard.
// A per-instruction reference trace is built from the sequencing rules and compared cycle by cycle.
module tb_core_ctrl_fsm;

    localparam logic [6:0] OP_REG       = 7'b0110011;
    localparam logic [6:0] OP_IMM_ARITH = 7'b0010011;
    localparam logic [6:0] OP_IMM_JUMP  = 7'b1100111;
    localparam logic [6:0] OP_IMM_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_U_L_LOAD  = 7'b0110111;
    localparam logic [6:0] OP_JUMP      = 7'b1101111;

    logic [6:0] legal_ops [8] = '{OP_REG, OP_IMM_ARITH, OP_IMM_JUMP, OP_IMM_LOAD,
                                  OP_STORE, OP_BRANCH, OP_U_L_LOAD, OP_JUMP};

    // Observable outputs of one cycle, packed so a whole cycle compares at once
    typedef struct packed {
        logic [2:0]  state;
        logic        imem_req;
        logic        ir_we;
        logic        pc_we;
        logic [1:0]  pc_sel;
        logic        alu_b_sel;
        logic        rf_we;
        logic [1:0]  wb_sel;
        logic        dmem_req;
        logic        dmem_we;
        logic        illegal;
        logic        retire;
        logic [31:0] retire_cnt;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  op_code_in;
    logic        imem_ack_in, dmem_ack_in, branch_taken_in;
    logic        imem_req_out, ir_we_out, pc_we_out, alu_b_sel_out, rf_we_out;
    logic        dmem_req_out, dmem_we_out, illegal_instr_out, retire_out;
    logic [1:0]  pc_sel_out, wb_sel_out;
    logic [31:0] retire_cnt_out;
    logic [2:0]  state_out;

    // Narrow-counter instance with a reset stall, for wrap and stall checks
    logic        w_rst;
    logic [6:0]  w_op;
    logic        w_imem_ack, w_dmem_ack, w_taken;
    logic        w_imem_req, w_ir_we, w_pc_we, w_alu_b_sel, w_rf_we;
    logic        w_dmem_req, w_dmem_we, w_illegal, w_retire;
    logic [1:0]  w_pc_sel, w_wb_sel;
    logic [2:0]  w_retire_cnt;
    logic [2:0]  w_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_cnt = 0;
    int          instr_no  = 0;
    obs_t        exp_q [$];
    string       tag_q [$];

    always #5 clk = ~clk;

    core_ctrl_fsm dut (
        .clk(clk), .rst(rst), .op_code_in(op_code_in),
        .imem_ack_in(imem_ack_in), .dmem_ack_in(dmem_ack_in), .branch_taken_in(branch_taken_in),
        .imem_req_out(imem_req_out), .ir_we_out(ir_we_out), .pc_we_out(pc_we_out),
        .pc_sel_out(pc_sel_out), .alu_b_sel_out(alu_b_sel_out), .rf_we_out(rf_we_out),
        .wb_sel_out(wb_sel_out), .dmem_req_out(dmem_req_out), .dmem_we_out(dmem_we_out),
        .illegal_instr_out(illegal_instr_out), .retire_out(retire_out),
        .retire_cnt_out(retire_cnt_out), .state_out(state_out)
    );

    core_ctrl_fsm #(.ARCH(3), .RESET_STALL(3)) dut_w (
        .clk(clk), .rst(w_rst), .op_code_in(w_op),
        .imem_ack_in(w_imem_ack), .dmem_ack_in(w_dmem_ack), .branch_taken_in(w_taken),
        .imem_req_out(w_imem_req), .ir_we_out(w_ir_we), .pc_we_out(w_pc_we),
        .pc_sel_out(w_pc_sel), .alu_b_sel_out(w_alu_b_sel), .rf_we_out(w_rf_we),
        .wb_sel_out(w_wb_sel), .dmem_req_out(w_dmem_req), .dmem_we_out(w_dmem_we),
        .illegal_instr_out(w_illegal), .retire_out(w_retire),
        .retire_cnt_out(w_retire_cnt), .state_out(w_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic obs_t sample_dut();
        obs_t o;
        o.state      = state_out;
        o.imem_req   = imem_req_out;
        o.ir_we      = ir_we_out;
        o.pc_we      = pc_we_out;
        o.pc_sel     = pc_sel_out;
        o.alu_b_sel  = alu_b_sel_out;
        o.rf_we      = rf_we_out;
        o.wb_sel     = wb_sel_out;
        o.dmem_req   = dmem_req_out;
        o.dmem_we    = dmem_we_out;
        o.illegal    = illegal_instr_out;
        o.retire     = retire_out;
        o.retire_cnt = retire_cnt_out;
        return o;
    endfunction

    function automatic obs_t idle(input logic [2:0] st);
        obs_t e = '0;
        e.state = st;
        return e;
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [6:0] rop();
        return 7'($urandom);
    endfunction

    function automatic logic rbit();
        return 1'($urandom);
    endfunction

    // Monitor: compare the DUT against the oldest expectation, mid-cycle
    initial begin
        forever begin
            obs_t  e;
            string t;
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check(t, sample_dut(), e);
            end
        end
    end

    // Apply one cycle of stimulus and queue the outputs it must produce
    task automatic drive(input logic [6:0] op, input logic ia, input logic da,
                         input logic bt, input obs_t e, input string tag);
        op_code_in      = op;
        imem_ack_in     = ia;
        dmem_ack_in     = da;
        branch_taken_in = bt;
        e.retire_cnt    = model_cnt;
        exp_q.push_back(e);
        tag_q.push_back($sformatf("%s[i%0d]", tag, instr_no));
        if (e.retire) model_cnt = model_cnt + 1;
        @(posedge clk);
        #1;
    endtask

    // Build and issue the reference cycle trace of one instruction, starting in FETCH.
    // Stops after DECODE for an illegal opcode.
    task automatic run_instr(input logic [6:0] op, input int imem_wait, input int dmem_wait,
                             input logic taken);
        obs_t e;
        logic is_mem   = (op == OP_IMM_LOAD) || (op == OP_STORE);
        logic is_store = (op == OP_STORE);
        instr_no++;
        for (int i = 0; i < imem_wait; i++) begin
            e = idle(3'd1); e.imem_req = 1'b1;
            drive(rop(), 1'b0, rbit(), rbit(), e, "fetch_wait");
        end
        e = idle(3'd1); e.imem_req = 1'b1; e.ir_we = 1'b1;
        drive(rop(), 1'b1, rbit(), rbit(), e, "fetch_ack");
        e = idle(3'd2);
        drive(op, rbit(), rbit(), rbit(), e, "decode");
        if (!is_legal(op)) return;

        e = idle(3'd3);
        e.alu_b_sel = (op == OP_IMM_ARITH) || (op == OP_IMM_LOAD) || is_store || (op == OP_IMM_JUMP);
        if (op == OP_BRANCH) begin
            e.pc_we  = 1'b1;
            e.pc_sel = taken ? 2'd1 : 2'd0;
            e.retire = 1'b1;
        end
        drive(rop(), rbit(), rbit(), taken, e, "exec");
        if (op == OP_BRANCH) return;

        if (is_mem) begin
            for (int i = 0; i < dmem_wait; i++) begin
                e = idle(3'd4); e.dmem_req = 1'b1; e.dmem_we = is_store;
                drive(rop(), rbit(), 1'b0, rbit(), e, "mem_wait");
            end
            e = idle(3'd4); e.dmem_req = 1'b1; e.dmem_we = is_store;
            e.pc_we = is_store; e.retire = is_store;
            drive(rop(), rbit(), 1'b1, rbit(), e, "mem_ack");
            if (is_store) return;
        end

        e = idle(3'd5);
        e.rf_we  = 1'b1;
        e.pc_we  = 1'b1;
        e.retire = 1'b1;
        e.wb_sel = (op == OP_IMM_LOAD) ? 2'd1 :
                   ((op == OP_JUMP) || (op == OP_IMM_JUMP)) ? 2'd2 :
                   (op == OP_U_L_LOAD) ? 2'd3 : 2'd0;
        e.pc_sel = (op == OP_JUMP) ? 2'd1 : (op == OP_IMM_JUMP) ? 2'd2 : 2'd0;
        drive(rop(), rbit(), rbit(), rbit(), e, "wb");
    endtask

    // Assert reset mid-cycle, check the outputs drop at once, release on a clean cycle boundary
    task automatic do_reset(input string name);
        obs_t r = idle(3'd1);
        imem_ack_in = 1'b0;
        dmem_ack_in = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check({name, "_async"}, sample_dut(), r);
        @(posedge clk);
        @(posedge clk);
        #1;
        check({name, "_held"}, sample_dut(), r);
        rst       = 1'b0;
        model_cnt = 0;
    endtask

    // Trap for an illegal opcode: flag set, everything else quiet, counter frozen
    task automatic run_trap(input logic [6:0] op);
        obs_t e;
        run_instr(op, $urandom_range(0, 2), 0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            e = idle(3'd6); e.illegal = 1'b1;
            drive(rop(), rbit(), rbit(), rbit(), e, "trap");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] bad;
        rst = 1'b0; op_code_in = '0; imem_ack_in = 1'b0; dmem_ack_in = 1'b0; branch_taken_in = 1'b0;
        w_rst = 1'b1; w_op = OP_JUMP; w_imem_ack = 1'b1; w_dmem_ack = 1'b1; w_taken = 1'b0;

        do_reset("reset_init");

        // Directed: one of each class, immediate and delayed acks
        run_instr(OP_REG,       0, 0, 1'b0);
        run_instr(OP_IMM_LOAD,  0, 2, 1'b0);
        run_instr(OP_BRANCH,    0, 0, 1'b1);
        run_instr(OP_BRANCH,    0, 0, 1'b0);
        run_instr(OP_JUMP,      0, 0, 1'b0);
        run_instr(OP_IMM_JUMP,  1, 0, 1'b0);
        run_instr(OP_U_L_LOAD,  0, 0, 1'b0);
        run_instr(OP_STORE,     2, 1, 1'b0);
        run_instr(OP_IMM_ARITH, 0, 0, 1'b0);

        // Random legal instruction stream with random wait states
        for (int n = 0; n < 200; n++) begin
            run_instr(legal_ops[$urandom_range(0, 7)], $urandom_range(0, 3),
                      $urandom_range(0, 3), rbit());
        end

        // Reset while a fetch is waiting for its ack
        instr_no++;
        for (int i = 0; i < 3; i++) begin
            obs_t e = idle(3'd1);
            e.imem_req = 1'b1;
            drive(rop(), 1'b0, rbit(), rbit(), e, "fetch_wait_pre_rst");
        end
        check("imem_req_before_rst", {63'd0, imem_req_out}, 64'd1);
        do_reset("reset_mid_fetch");
        run_instr(OP_REG, 0, 0, 1'b0);

        // Illegal opcodes
        run_trap(7'h7F);
        do_reset("reset_after_trap");
        do bad = rop(); while (is_legal(bad));
        run_instr(OP_STORE, 0, 0, 1'b0);
        run_trap(bad);
        do_reset("reset_after_trap2");
        for (int n = 0; n < 10; n++) begin
            run_instr(legal_ops[$urandom_range(0, 7)], $urandom_range(0, 2),
                      $urandom_range(0, 2), rbit());
        end

        // Narrow instance: quiet during reset, 3 stall cycles, then a JUMP loop that wraps the counter
        check("w_reset_state", {w_state, w_imem_req, w_pc_we, w_retire, w_retire_cnt, w_illegal},
              {3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0});
        w_rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("w_stall_cycle%0d", c), {w_state, w_imem_req}, {3'd0, 1'b0});
        end
        @(negedge clk);
        check("w_first_fetch", {w_state, w_imem_req, w_ir_we}, {3'd1, 1'b1, 1'b1});
        for (int k = 0; k < 8; k++) begin
            repeat (3) @(negedge clk);
            check($sformatf("w_jump_wb%0d", k), {w_state, w_pc_sel, w_wb_sel, w_rf_we, w_retire, w_retire_cnt},
                  {3'd5, 2'd1, 2'd2, 1'b1, 1'b1, 3'(k)});
            @(negedge clk);
            check($sformatf("w_cnt_after%0d", k), {w_state, w_retire_cnt}, {3'd1, 3'((k + 1) % 8)});
        end

        @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
